uart_tx_serializer: RTL and testbench

UART transmit stage that consumes the single-cycle baud tick from the team's baud tick generator. Each byte handed over on a valid/ready interface becomes a serial frame on tx: start bit, LSB-first data, optional parity, then 1 or 2 stop bits. Each bit lasts exactly one tick interval. The block sits between the system-side TX FIFO/CPU register and the pad.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_serializer.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types, line levels and parity helper (TX and RX).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// ============================================================================
// Module   : uart_tx_serializer
// Brief    : Baud-tick driven UART transmitter, valid/ready byte input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int                CNT_W       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0]  c_last_bit  = CNT_W'(DATA_BITS - 1);
  localparam logic              c_last_stop = 1'(STOP_BITS - 1);
  localparam logic              c_odd       = (PARITY_ODD != 0);

  uart_state_e          r_state, w_state_next;
  logic                 r_tx, w_tx_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic                 r_parity, w_parity_next;
  logic                 r_pending, w_pending_next;
  logic [CNT_W-1:0]     r_bit_cnt, w_bit_cnt_next;
  logic                 r_stop_cnt, w_stop_cnt_next;

  logic w_final_stop;
  logic w_accept;
  logic w_new_parity;

  assign w_final_stop = (r_state == ST_STOP) && (r_stop_cnt == c_last_stop);
  assign tx_ready     = (r_state == ST_IDLE) || (w_final_stop && !r_pending);
  assign w_accept     = tx_valid && tx_ready;
  assign w_new_parity = calc_parity(9'(tx_data), c_odd);
  assign tx           = r_tx;
  assign busy         = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tx       <= UART_IDLE_LEVEL;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_pending  <= 1'b0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tx       <= w_tx_next;
      r_shift    <= w_shift_next;
      r_parity   <= w_parity_next;
      r_pending  <= w_pending_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_stop_cnt <= w_stop_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_tx_next       = r_tx;
    w_shift_next    = r_shift;
    w_parity_next   = r_parity;
    w_pending_next  = r_pending;
    w_bit_cnt_next  = r_bit_cnt;
    w_stop_cnt_next = r_stop_cnt;

    case (r_state)
      ST_IDLE: begin
        w_tx_next = UART_IDLE_LEVEL;
        // A tick coinciding with the accept is deliberately not used.
        if (w_accept) begin
          w_shift_next  = tx_data;
          w_parity_next = w_new_parity;
          w_state_next  = ST_ARM;
        end
      end

      ST_ARM: begin
        if (baud_tick) begin
          w_state_next = ST_START;
          w_tx_next    = UART_START_LEVEL;
        end
      end

      ST_START: begin
        if (baud_tick) begin
          w_state_next   = ST_DATA;
          w_tx_next      = r_shift[0];
          w_shift_next   = r_shift >> 1;
          w_bit_cnt_next = '0;
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          if (r_bit_cnt == c_last_bit) begin
            if (PARITY_EN != 0) begin
              w_state_next = ST_PARITY;
              w_tx_next    = r_parity;
            end else begin
              w_state_next    = ST_STOP;
              w_tx_next       = UART_IDLE_LEVEL;
              w_stop_cnt_next = 1'b0;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
            w_tx_next      = r_shift[0];
            w_shift_next   = r_shift >> 1;
          end
        end
      end

      ST_PARITY: begin
        if (baud_tick) begin
          w_state_next    = ST_STOP;
          w_tx_next       = UART_IDLE_LEVEL;
          w_stop_cnt_next = 1'b0;
        end
      end

      ST_STOP: begin
        w_tx_next = UART_IDLE_LEVEL;
        if (w_accept) begin
          w_shift_next   = tx_data;
          w_parity_next  = w_new_parity;
          w_pending_next = 1'b1;
        end
        if (baud_tick) begin
          if (!w_final_stop) begin
            w_stop_cnt_next = 1'b1;
          end else if (r_pending || w_accept) begin
            // Back-to-back frame: start bit follows the stop bit with no idle gap.
            w_state_next   = ST_START;
            w_tx_next      = UART_START_LEVEL;
            w_pending_next = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_tx_next    = UART_IDLE_LEVEL;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
// ============================================================================
// Module   : tb_uart_tx_serializer
// Brief    : Self-checking bench for uart_tx_serializer in 8N1/8E1/8O1/8N2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_serializer;

  typedef struct {
    int          idx;
    logic [7:0]  data;
    logic [23:0] frame;
    int          len;
    string       name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick;
  logic [1:0] r_tick_cnt = 2'd0;
  logic [3:0] valid_r = 4'b0;
  logic [7:0] data_r [4];
  logic [3:0] tx_w, busy_w, ready_w;

  int checks   = 0;
  int failures = 0;
  int acc_cnt [4] = '{default: 0};

  // Instance configuration: 0=8N1, 1=8E1, 2=8O1, 3=8N2
  int cfg_pen  [4] = '{0, 1, 1, 0};
  int cfg_odd  [4] = '{0, 0, 1, 0};
  int cfg_stop [4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  // Free-running tick every 4 clocks
  always @(posedge clk) r_tick_cnt <= r_tick_cnt + 2'd1;
  assign baud_tick = (r_tick_cnt == 2'd3);

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (!rst && valid_r[i] && ready_w[i]) acc_cnt[i] <= acc_cnt[i] + 1;
  end

  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data_r[0]), .tx_valid(valid_r[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data_r[1]), .tx_valid(valid_r[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data_r[2]), .tx_valid(valid_r[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data_r[3]), .tx_valid(valid_r[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

  // Reference frame, bit 0 sent first: start, data LSB-first, optional parity, stops.
  function automatic logic [11:0] frame_of(input logic [7:0] b, input int idx);
    logic [11:0] f;
    int          pos;
    f      = '0;
    f[8:1] = b;
    pos    = 9;
    if (cfg_pen[idx] != 0) begin
      f[pos] = (^b) ^ (cfg_odd[idx] != 0);
      pos++;
    end
    for (int s = 0; s < cfg_stop[idx]; s++) begin
      f[pos] = 1'b1;
      pos++;
    end
    return f;
  endfunction

  function automatic int len_of(input int idx);
    return 9 + cfg_pen[idx] + cfg_stop[idx];
  endfunction

  task automatic send(input int idx, input logic [7:0] b);
    @(negedge clk);
    data_r[idx]  = b;
    valid_r[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_r[idx] = 1'b0;
  endtask

  task automatic check_frame(input int idx, input logic [23:0] exp, input int len,
                             input bit chk_ready, input string name);
    int   n;
    bit   ok;
    logic exp_rdy;
    n = 0;
    while (tx_w[idx] !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (tx_w[idx] !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL %s start-bit timeout: tx=%b required 0", name, tx_w[idx]);
      return;
    end
    for (int i = 0; i < len; i++) begin
      ok      = 1'b1;
      exp_rdy = (i == len - 1);
      for (int c = 0; c < 4; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (tx_w[idx] !== exp[i] || busy_w[idx] !== 1'b1 ||
            (chk_ready && ready_w[idx] !== exp_rdy)) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL %s bit %0d: tx=%b busy=%b ready=%b required tx=%b busy=1 ready=%b",
                 name, i, tx_w[idx], busy_w[idx], ready_w[idx], exp[i], exp_rdy);
      end
    end
  endtask

  task automatic check_idle(input int idx, input string name);
    @(negedge clk);
    checks++;
    if (tx_w[idx] !== 1'b1 || busy_w[idx] !== 1'b0 || ready_w[idx] !== 1'b1) begin
      failures++;
      $display("FAIL %s idle: tx=%b busy=%b ready=%b required tx=1 busy=0 ready=1",
               name, tx_w[idx], busy_w[idx], ready_w[idx]);
    end
  endtask

  initial begin
    vec_t        tbl [5];
    bit          ok;
    int          n;
    int          base;
    logic [11:0] f1, f2;
    logic [7:0]  b;

    tbl[0] = '{0, 8'hA5, 24'h00034A, 10, "8N1_A5"};
    tbl[1] = '{1, 8'h07, 24'h00060E, 11, "8E1_07"};
    tbl[2] = '{2, 8'h07, 24'h00040E, 11, "8O1_07"};
    tbl[3] = '{3, 8'hFF, 24'h0007FE, 11, "8N2_FF"};
    tbl[4] = '{0, 8'h3C, 24'h000278, 10, "8N1_3C"};
    for (int i = 0; i < 4; i++) data_r[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || ready_w[i] !== 1'b1) begin
        failures++;
        $display("FAIL reset_state u%0d: tx=%b busy=%b ready=%b required tx=1 busy=0 ready=1",
                 i, tx_w[i], busy_w[i], ready_w[i]);
      end
    end
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].idx, tbl[i].data);
      check_frame(tbl[i].idx, tbl[i].frame, tbl[i].len, 1'b1, tbl[i].name);
      check_idle(tbl[i].idx, tbl[i].name);
    end

    // Accept together with a tick in IDLE: that tick must not start the frame
    @(negedge clk);
    while (!baud_tick) @(negedge clk);
    data_r[0]  = 8'hC3;
    valid_r[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_r[0] = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      if (tx_w[0] !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL tick_ignored: tx went low early, required 1 for 4 clks");
    end
    @(negedge clk);
    checks++;
    if (tx_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL tick_ignored_start: tx=%b required 0", tx_w[0]);
    end
    check_frame(0, 24'(frame_of(8'hC3, 0)), len_of(0), 1'b1, "tick_ignored_frame");
    check_idle(0, "tick_ignored_frame");

    // Back-to-back with tx_valid held high
    base = acc_cnt[0];
    f1   = frame_of(8'h55, 0);
    f2   = frame_of(8'hAA, 0);
    @(negedge clk);
    data_r[0]  = 8'h55;
    valid_r[0] = 1'b1;
    fork
      begin
        n = 0;
        while (acc_cnt[0] < base + 1 && n < 100) begin @(negedge clk); n++; end
        data_r[0] = 8'hAA;
        while (acc_cnt[0] < base + 2 && n < 100) begin @(negedge clk); n++; end
        valid_r[0] = 1'b0;
      end
      check_frame(0, {4'b0, f2[9:0], f1[9:0]}, 20, 1'b0, "back_to_back");
    join
    check_idle(0, "back_to_back");
    checks++;
    if (acc_cnt[0] - base != 2) begin
      failures++;
      $display("FAIL b2b_accepts: got %0d required 2", acc_cnt[0] - base);
    end

    // Reset during data bit 3 of 0x0F
    send(0, 8'h0F);
    n = 0;
    while (tx_w[0] !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || ready_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: tx=%b busy=%b ready=%b required tx=1 busy=0 ready=1",
               tx_w[0], busy_w[0], ready_w[0]);
    end
    rst = 1'b0;
    ok  = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_reset_discard: line activity after reset, required idle");
    end
    send(0, 8'h3C);
    check_frame(0, 24'h000278, 10, 1'b1, "after_reset_3C");
    check_idle(0, "after_reset_3C");

    // Randomized bytes on every configuration
    for (int r = 0; r < 6; r++) begin
      for (int d = 0; d < 4; d++) begin
        b = 8'($urandom);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(d, b);
        check_frame(d, 24'(frame_of(b, d)), len_of(d), 1'b1, $sformatf("rand_u%0d_%02h", d, b));
        check_idle(d, "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
